// File: rtl/cmp_result_monitor.sv
// Scoreboard front-end for the 4-bit comparator: registers each valid {Y2,Y1,Y0}
// result, tracks the last legal outcome, counts outcomes and flags equal runs / illegal flags.
module cmp_result_monitor #(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             Y0,
    input  logic             Y1,
    input  logic             Y2,
    input  logic             clr,
    output logic             out_valid,
    output logic [1:0]       last_res,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             eq_run,
    output logic             err
);

    if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
        $error("cmp_result_monitor: RUN_LEN must be in 2..255");
    end

    // State encoding doubles as the last_res output code.
    typedef enum logic [1:0] {
        S_NONE = 2'b00,
        S_LT   = 2'b01,
        S_EQ   = 2'b10,
        S_GT   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [7:0]       RUN_THR = 8'(RUN_LEN);
    localparam logic [7:0]       RUN_MAX = 8'hFF;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [7:0]       run_q, run_d;
    logic             out_valid_q, out_valid_d;
    logic             eq_run_q, eq_run_d;
    logic             err_q, err_d;

    logic [2:0] flags;
    logic       is_gt, is_eq, is_lt;
    logic       accept, legal;

    assign flags  = {Y2, Y1, Y0};
    assign is_gt  = (flags == 3'b100);
    assign is_eq  = (flags == 3'b010);
    assign is_lt  = (flags == 3'b001);
    // clr outranks a sample presented in the same cycle.
    assign accept = in_valid && !clr;
    assign legal  = is_gt || is_eq || is_lt;

    // FSM: next state is simply the class of the latest legal sample.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        if (clr) begin
            state_d = S_NONE;
        end else if (accept) begin
            if (is_gt)      state_d = S_GT;
            else if (is_eq) state_d = S_EQ;
            else if (is_lt) state_d = S_LT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
            state_q <= S_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        gt_cnt_d    = gt_cnt_q;
        eq_cnt_d    = eq_cnt_q;
        lt_cnt_d    = lt_cnt_q;
        run_d       = run_q;
        err_d       = err_q;
        out_valid_d = accept;

        if (clr) begin
            gt_cnt_d = '0;
            eq_cnt_d = '0;
            lt_cnt_d = '0;
            run_d    = '0;
            err_d    = 1'b0;
        end else if (accept) begin
            if (!legal) begin
                err_d = 1'b1;
                run_d = '0;
            end else if (is_eq) begin
                if (eq_cnt_q != CNT_MAX) eq_cnt_d = eq_cnt_q + CNT_ONE;
                if (run_q != RUN_MAX)    run_d    = run_q + 8'd1;
            end else begin
                run_d = '0;
                if (is_gt && gt_cnt_q != CNT_MAX) gt_cnt_d = gt_cnt_q + CNT_ONE;
                if (is_lt && lt_cnt_q != CNT_MAX) lt_cnt_d = lt_cnt_q + CNT_ONE;
            end
        end

        // Judged on the updated run length so the flag rises with the RUN_LEN-th count.
        eq_run_d = (run_d >= RUN_THR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_cnt_q    <= '0;
            eq_cnt_q    <= '0;
            lt_cnt_q    <= '0;
            run_q       <= '0;
            out_valid_q <= 1'b0;
            eq_run_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            gt_cnt_q    <= gt_cnt_d;
            eq_cnt_q    <= eq_cnt_d;
            lt_cnt_q    <= lt_cnt_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            eq_run_q    <= eq_run_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign last_res  = state_q;
    assign gt_cnt    = gt_cnt_q;
    assign eq_cnt    = eq_cnt_q;
    assign lt_cnt    = lt_cnt_q;
    assign eq_run    = eq_run_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Bench for cmp_result_monitor: directed vector table, corner sequences and a random
// stream against an outcome-counting reference model (two instances: CNT_W=8 and CNT_W=2).
module tb_cmp_result_monitor;

    localparam int RUN_LEN = 3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       Y0, Y1, Y2;
    logic       clr;

    logic       out_valid_a, eq_run_a, err_a;
    logic [1:0] last_res_a;
    logic [7:0] gt_cnt_a, eq_cnt_a, lt_cnt_a;

    logic       out_valid_b, eq_run_b, err_b;
    logic [1:0] last_res_b;
    logic [1:0] gt_cnt_b, eq_cnt_b, lt_cnt_b;

    cmp_result_monitor #(.CNT_W(8), .RUN_LEN(RUN_LEN)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .clr(clr),
        .out_valid(out_valid_a), .last_res(last_res_a),
        .gt_cnt(gt_cnt_a), .eq_cnt(eq_cnt_a), .lt_cnt(lt_cnt_a),
        .eq_run(eq_run_a), .err(err_a)
    );

    cmp_result_monitor #(.CNT_W(2), .RUN_LEN(RUN_LEN)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .clr(clr),
        .out_valid(out_valid_b), .last_res(last_res_b),
        .gt_cnt(gt_cnt_b), .eq_cnt(eq_cnt_b), .lt_cnt(lt_cnt_b),
        .eq_run(eq_run_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: raw outcome tallies since the last clear; saturation applied on compare.
    int m_last;   // 0 none, 1 lt, 2 eq, 3 gt
    int m_gt, m_eq, m_lt, m_run;
    bit m_err, m_ov;

    function automatic int cap(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_clear();
        m_last = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_run = 0; m_err = 0; m_ov = 0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] y, input logic c);
        if (c) begin
            model_clear();
        end else if (!v) begin
            m_ov = 0;
        end else begin
            m_ov = 1;
            if ($countones(y) != 1) begin
                m_err = 1;
                m_run = 0;
            end else if (y[2]) begin
                m_last = 3; m_gt++; m_run = 0;
            end else if (y[1]) begin
                m_last = 2; m_eq++; m_run = cap(m_run + 1, 255);
            end else begin
                m_last = 1; m_lt++; m_run = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".a.ov"},  out_valid_a, m_ov);
        check({tag, ".a.lr"},  last_res_a,  m_last);
        check({tag, ".a.gt"},  gt_cnt_a,    cap(m_gt, 255));
        check({tag, ".a.eq"},  eq_cnt_a,    cap(m_eq, 255));
        check({tag, ".a.lt"},  lt_cnt_a,    cap(m_lt, 255));
        check({tag, ".a.run"}, eq_run_a,    (m_run >= RUN_LEN));
        check({tag, ".a.err"}, err_a,       m_err);
        check({tag, ".b.lr"},  last_res_b,  m_last);
        check({tag, ".b.gt"},  gt_cnt_b,    cap(m_gt, 3));
        check({tag, ".b.eq"},  eq_cnt_b,    cap(m_eq, 3));
        check({tag, ".b.lt"},  lt_cnt_b,    cap(m_lt, 3));
        check({tag, ".b.err"}, err_b,       m_err);
    endtask

    // Drive one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic v, input logic [2:0] y, input logic c);
        in_valid = v;
        {Y2, Y1, Y0} = y;
        clr = c;
        @(posedge clk);
        model_step(v, y, c);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [2:0] y;
        logic       c;
        logic       ov;
        logic [1:0] lr;
        int         gt, eq, lt;
        logic       er;
        logic       err;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] y, input logic c,
                                input logic ov, input logic [1:0] lr,
                                input int gt, input int eq, input int lt,
                                input logic er, input logic err_e);
        vec_t r;
        r.v = v; r.y = y; r.c = c; r.ov = ov; r.lr = lr;
        r.gt = gt; r.eq = eq; r.lt = lt; r.er = er; r.err = err_e;
        return r;
    endfunction

    vec_t tbl[18];

    initial begin
        int sat_exp[5];
        logic [2:0] y;

        //            v  y       c  ov lr     gt eq lt er err
        tbl[0]  = mk(1, 3'b100, 0, 1, 2'b11, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 3'b001, 0, 1, 2'b01, 1, 0, 1, 0, 0);
        tbl[2]  = mk(1, 3'b010, 0, 1, 2'b10, 1, 1, 1, 0, 0);
        tbl[3]  = mk(1, 3'b100, 0, 1, 2'b11, 2, 1, 1, 0, 0);
        tbl[4]  = mk(1, 3'b010, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 3'b010, 0, 1, 2'b10, 0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 3'b010, 0, 1, 2'b10, 0, 2, 0, 0, 0);
        tbl[7]  = mk(0, 3'b010, 0, 0, 2'b10, 0, 2, 0, 0, 0);
        tbl[8]  = mk(1, 3'b010, 0, 1, 2'b10, 0, 3, 0, 1, 0);
        tbl[9]  = mk(1, 3'b100, 0, 1, 2'b11, 1, 3, 0, 0, 0);
        tbl[10] = mk(1, 3'b110, 0, 1, 2'b11, 1, 3, 0, 0, 1);
        tbl[11] = mk(1, 3'b000, 0, 1, 2'b11, 1, 3, 0, 0, 1);
        tbl[12] = mk(1, 3'b010, 0, 1, 2'b10, 1, 4, 0, 0, 1);
        tbl[13] = mk(1, 3'b010, 0, 1, 2'b10, 1, 5, 0, 0, 1);
        tbl[14] = mk(1, 3'b010, 0, 1, 2'b10, 1, 6, 0, 1, 1);
        tbl[15] = mk(1, 3'b101, 0, 1, 2'b10, 1, 6, 0, 0, 1);
        tbl[16] = mk(0, 3'b111, 0, 0, 2'b10, 1, 6, 0, 0, 1);
        tbl[17] = mk(0, 3'b000, 1, 0, 2'b00, 0, 0, 0, 0, 0);

        sat_exp = '{1, 2, 3, 3, 3};

        rst_n = 1'b0; in_valid = 1'b0; {Y2, Y1, Y0} = 3'b000; clr = 1'b0;
        model_clear();
        #13;
        check_model("reset");
        check("reset.a.ov_const", out_valid_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].y, tbl[i].c);
            check($sformatf("vec%0d.ov", i),  out_valid_a, tbl[i].ov);
            check($sformatf("vec%0d.lr", i),  last_res_a,  tbl[i].lr);
            check($sformatf("vec%0d.gt", i),  gt_cnt_a,    tbl[i].gt);
            check($sformatf("vec%0d.eq", i),  eq_cnt_a,    tbl[i].eq);
            check($sformatf("vec%0d.lt", i),  lt_cnt_a,    tbl[i].lt);
            check($sformatf("vec%0d.run", i), eq_run_a,    tbl[i].er);
            check($sformatf("vec%0d.err", i), err_a,       tbl[i].err);
        end

        // Saturation of the narrow instance.
        step(0, 3'b000, 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 3'b100, 0);
            check($sformatf("sat%0d.b.gt", k), gt_cnt_b, sat_exp[k]);
            check($sformatf("sat%0d.b.eq", k), eq_cnt_b, 0);
            check($sformatf("sat%0d.b.lt", k), lt_cnt_b, 0);
        end
        for (int k = 0; k < 300; k++) step(1, 3'b100, 0);
        check("sat8.a.gt", gt_cnt_a, 255);
        check_model("sat8");

        // Run counter saturation: a long equal run keeps eq_run high, a lt ends it.
        for (int k = 0; k < 260; k++) step(1, 3'b010, 0);
        check("longrun.a.run", eq_run_a, 1);
        check_model("longrun");
        step(1, 3'b001, 0);
        check("longrun_end.a.run", eq_run_a, 0);
        check_model("longrun_end");

        // Asynchronous reset in the middle of an equal run.
        for (int k = 0; k < 4; k++) step(1, 3'b010, 0);
        #3 rst_n = 1'b0;
        #1;
        model_clear();
        check("areset.a.run", eq_run_a, 0);
        check("areset.a.eq", eq_cnt_a, 0);
        check_model("areset");
        #2 rst_n = 1'b1;
        step(1, 3'b010, 0);
        check("after_rst.a.lr", last_res_a, 2'b10);
        check("after_rst.a.eq", eq_cnt_a, 1);
        check_model("after_rst");

        // Random stream against the reference model.
        for (int k = 0; k < 1500; k++) begin
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 4)       y = 3'b010;
            else if (pick < 6)  y = 3'b100;
            else if (pick < 8)  y = 3'b001;
            else                y = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 3) != 0), y, ($urandom_range(0, 99) == 0));
            check_model($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
